round_const_gen: RTL and testbench

ROUND_CONST_GEN -- requirements
Module: round_const_gen

---
 rtl/round_const_gen.sv | 192 +++++++++++++++++++
 tb/tb_round_const_gen.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/round_const_gen.sv
// Round-constant generator: 6-bit LFSR expanded into a ROWS x COLS cell matrix, streamed with valid/ready.
// Optional RC_INVERSE_EN adds inverse (last-round-first) sequencing through a PRELOAD phase.
module round_const_gen #(
    parameter int          ROWS       = 4,
    parameter int          COLS       = 4,
    parameter int          NIB_W      = 4,
    parameter int          NUM_ROUNDS = 32,
    parameter logic [5:0]  RC_INIT    = 6'h01
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         mode_i,
    input  logic                         abort_i,
    input  logic                         rc_ready_i,
    output logic                         rc_valid_o,
    output logic [ROWS*COLS*NIB_W-1:0]   round_cnst_o,
    output logic [5:0]                   round_idx_o,
    output logic                         busy_o,
    output logic                         done_o
);
    localparam int         CW      = ROWS * COLS * NIB_W;
    localparam logic [5:0] LAST    = 6'(NUM_ROUNDS - 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
`ifdef RC_INVERSE_EN
    localparam logic [1:0] S_PRELOAD = 2'd1;
`endif
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    function automatic logic [5:0] lfsr_next(input logic [5:0] rc);
        return {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
    endfunction

`ifdef RC_INVERSE_EN
    function automatic logic [5:0] lfsr_prev(input logic [5:0] rc);
        return {rc[0] ^ rc[5] ^ 1'b1, rc[5:1]};
    endfunction
`endif

    function automatic logic [CW-1:0] build_cnst(input logic [5:0] rc);
        logic [CW-1:0] m;
        logic [7:0]    sh;
        m = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r >= 1) begin
                sh = 8'd1 << (r - 1);
                m[(r*COLS + COLS - 2)*NIB_W +: NIB_W] = sh[NIB_W-1:0];
            end
            if (r % 2 == 0)
                m[(r*COLS + COLS - 1)*NIB_W +: NIB_W] = {{(NIB_W-3){1'b0}}, rc[5:3]};
            else
                m[(r*COLS + COLS - 1)*NIB_W +: NIB_W] = {{(NIB_W-3){1'b0}}, rc[2:0]};
        end
        return m;
    endfunction

    logic [1:0]    state_q, state_d;
    logic [5:0]    rc_q, rc_d;
    logic [5:0]    idx_q, idx_d;
    logic [CW-1:0] cnst_q, cnst_d;
    logic          vld_q, vld_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          load;
    logic          inv;
`ifdef RC_INVERSE_EN
    logic          mode_q, mode_d;
    assign inv = mode_q;
`else
    logic          unused_mode;
    assign unused_mode = mode_i;
    assign inv         = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        load    = 1'b0;
`ifdef RC_INVERSE_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    rc_d  = RC_INIT;
                    idx_d = 6'd0;
`ifdef RC_INVERSE_EN
                    mode_d = mode_i;
                    if (mode_i && NUM_ROUNDS > 1) begin
                        state_d = S_PRELOAD;
                    end else begin
                        state_d = S_RUN;
                        vld_d   = 1'b1;
                        load    = 1'b1;
                    end
`else
                    state_d = S_RUN;
                    vld_d   = 1'b1;
                    load    = 1'b1;
`endif
                end
            end
`ifdef RC_INVERSE_EN
            // Walk forward to the last round's value; the final step lands in RUN.
            S_PRELOAD: begin
                rc_d  = lfsr_next(rc_q);
                idx_d = idx_q + 6'd1;
                if (idx_q == LAST - 6'd1) begin
                    state_d = S_RUN;
                    vld_d   = 1'b1;
                    load    = 1'b1;
                end
            end
`endif
            S_RUN: begin
                if (vld_q && rc_ready_i) begin
                    if (idx_q == (inv ? 6'd0 : LAST)) begin
                        state_d = S_DONE;
                        vld_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        load = 1'b1;
`ifdef RC_INVERSE_EN
                        if (inv) begin
                            rc_d  = lfsr_prev(rc_q);
                            idx_d = idx_q - 6'd1;
                        end else begin
                            rc_d  = lfsr_next(rc_q);
                            idx_d = idx_q + 6'd1;
                        end
`else
                        rc_d  = lfsr_next(rc_q);
                        idx_d = idx_q + 6'd1;
`endif
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                vld_d   = 1'b0;
            end
        endcase
        // Abort overrides any handshake, including the final one.
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
            rc_d    = rc_q;
            idx_d   = idx_q;
            vld_d   = 1'b0;
            done_d  = 1'b0;
            load    = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
        cnst_d = load ? build_cnst(rc_d) : cnst_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            rc_q    <= RC_INIT;
            idx_q   <= 6'd0;
            cnst_q  <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef RC_INVERSE_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            idx_q   <= idx_d;
            cnst_q  <= cnst_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef RC_INVERSE_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign rc_valid_o   = vld_q;
    assign round_cnst_o = cnst_q;
    assign round_idx_o  = idx_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
endmodule

// File: tb/tb_round_const_gen.sv
// Directed bench for round_const_gen: default 4x4 instance plus a 2x3 single-round instance.
module tb_round_const_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mode, abort, ready;
    logic        vld, busy, done;
    logic [63:0] cnst;
    logic [5:0]  idx;

    logic        start_b, mode_b, abort_b, ready_b;
    logic        vld_b, busy_b, done_b;
    logic [23:0] cnst_b;
    logic [5:0]  idx_b;

    round_const_gen dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode), .abort_i(abort),
        .rc_ready_i(ready), .rc_valid_o(vld), .round_cnst_o(cnst), .round_idx_o(idx),
        .busy_o(busy), .done_o(done)
    );

    round_const_gen #(.ROWS(2), .COLS(3), .NIB_W(4), .NUM_ROUNDS(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .start_i(start_b), .mode_i(mode_b), .abort_i(abort_b),
        .rc_ready_i(ready_b), .rc_valid_o(vld_b), .round_cnst_o(cnst_b), .round_idx_o(idx_b),
        .busy_o(busy_b), .done_o(done_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        int          beat;
        logic [63:0] cnst;
    } vec_t;
    vec_t tbl[6];

    initial begin
        int lat;
        // beat -> expected matrix (rc 01, 07, 0F, 3E, 38, 1E)
        tbl[0] = '{0,  64'h1400_0200_1100_0000};
        tbl[1] = '{2,  64'h7400_0200_7100_0000};
        tbl[2] = '{3,  64'h7400_1200_7100_1000};
        tbl[3] = '{5,  64'h6400_7200_6100_7000};
        tbl[4] = '{31, 64'h0400_7200_0100_7000};
        tbl[5] = '{10, 64'h6400_3200_6100_3000};

        rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0; ready = 1'b0;
        start_b = 1'b0; mode_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
        tick; tick;
        chk("rst_vld", 64'(vld), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_idx", 64'(idx), 64'd0);
        chk("rst_cnst", cnst, 64'd0);
        rst = 1'b0;
        tick;

        // Forward run, consumer always ready
        start = 1'b1; ready = 1'b1;
        tick;
        start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            chk("fwd_vld", 64'(vld), 64'd1);
            chk("fwd_idx", 64'(idx), 64'(b));
            for (int t = 0; t < 6; t++)
                if (tbl[t].beat == b) chk("fwd_cnst", cnst, tbl[t].cnst);
            tick;
        end
        chk("fwd_done", 64'(done), 64'd1);
        chk("fwd_vld_off", 64'(vld), 64'd0);
        tick;
        chk("fwd_done_1cyc", 64'(done), 64'd0);
        chk("fwd_idle", 64'(busy), 64'd0);

        // Backpressure hold at beat 2
        start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("stall_idx", 64'(idx), 64'd2);
            chk("stall_cnst", cnst, tbl[1].cnst);
            tick;
        end
        ready = 1'b1;
        chk("stall_idx4", 64'(idx), 64'd2);
        chk("stall_cnst4", cnst, tbl[1].cnst);
        tick;
        chk("stall_next_idx", 64'(idx), 64'd3);
        chk("stall_next_cnst", cnst, tbl[2].cnst);
        abort = 1'b1;
        tick;
        abort = 1'b0;
        chk("abort_mid_busy", 64'(busy), 64'd0);
        chk("abort_mid_vld", 64'(vld), 64'd0);

        // Abort coinciding with the final handshake, start in the same cycle
        start = 1'b1;
        tick;
        start = 1'b0;
        repeat (31) tick;
        chk("fin_idx", 64'(idx), 64'd31);
        abort = 1'b1; start = 1'b1;
        tick;
        abort = 1'b0; start = 1'b0;
        chk("abort_fin_busy", 64'(busy), 64'd0);
        chk("abort_fin_vld", 64'(vld), 64'd0);
        chk("abort_fin_done", 64'(done), 64'd0);
        tick;
        chk("abort_fin_done2", 64'(done), 64'd0);
        chk("abort_fin_idle", 64'(busy), 64'd0);
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("restart_vld", 64'(vld), 64'd1);
        chk("restart_idx", 64'(idx), 64'd0);
        chk("restart_cnst", cnst, tbl[0].cnst);

        // Start ignored while running, then reset at beat 10
        repeat (5) tick;
        start = 1'b1;
        tick;
        start = 1'b0;
        chk("start_in_run", 64'(idx), 64'd6);
        repeat (4) tick;
        chk("b10_idx", 64'(idx), 64'd10);
        chk("b10_cnst", cnst, tbl[5].cnst);
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        tick;
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        chk("mrst_vld", 64'(vld), 64'd0);
        chk("mrst_idx", 64'(idx), 64'd0);
        chk("mrst_cnst", cnst, 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        tick;
        chk("mrst_start_lost", 64'(busy), 64'd0);

`ifdef RC_INVERSE_EN
        // Inverse: PRELOAD then count down; mode only matters on acceptance
        mode = 1'b1; start = 1'b1;
        tick;
        start = 1'b0; mode = 1'b0;
        lat = 1;
        chk("inv_pre_vld", 64'(vld), 64'd0);
        chk("inv_pre_busy", 64'(busy), 64'd1);
        while (!vld && lat < 40) begin
            tick;
            lat++;
        end
        chk("inv_latency", 64'(lat), 64'd32);
        chk("inv_first_idx", 64'(idx), 64'd31);
        chk("inv_first_cnst", cnst, tbl[4].cnst);
        repeat (31) tick;
        chk("inv_last_idx", 64'(idx), 64'd0);
        chk("inv_last_cnst", cnst, tbl[0].cnst);
        tick;
        chk("inv_done", 64'(done), 64'd1);
        tick;
`else
        // Without inverse support mode is ignored
        mode = 1'b1; start = 1'b1;
        tick;
        start = 1'b0; mode = 1'b0;
        chk("nomode_vld", 64'(vld), 64'd1);
        chk("nomode_idx", 64'(idx), 64'd0);
        chk("nomode_cnst", cnst, tbl[0].cnst);
        abort = 1'b1;
        tick;
        abort = 1'b0;
`endif

        // Small single-round instance
        start_b = 1'b1;
        tick;
        start_b = 1'b0;
        chk("small_vld", 64'(vld_b), 64'd1);
        chk("small_idx", 64'(idx_b), 64'd0);
        chk("small_cnst", 64'(cnst_b), 64'h11_0000);
        chk("small_busy", 64'(busy_b), 64'd1);
        tick;
        chk("small_done", 64'(done_b), 64'd1);
        chk("small_vld_off", 64'(vld_b), 64'd0);
        tick;
        chk("small_done_1cyc", 64'(done_b), 64'd0);
        chk("small_idle", 64'(busy_b), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
